// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, board geometry and the cell-index helper
// used by the VGA raster generator.
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int BOARD_X0 = 80;
  localparam int CELL_SZ  = 160;

  localparam logic [3:0] CELL_NONE = 4'd15;
  // Row/column tracker value meaning "outside the 3x3 board".
  localparam logic [1:0] IDX_NONE  = 2'd3;

  function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
    return 4'({row, 1'b0}) + 4'(row) + 4'(col);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Pixel-tick divider: a registered one-clock tick every DIV system clocks,
// high in the clock where the internal count sits at DIV-1.
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    if (cnt == LAST) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // Tick is registered from the next count so it lines up with cnt == DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel coordinates, blanking, syncs and frame strobe, all from one
// register stage. Defining VGA_CELL_COORD_EN adds 3x3 board cell/lx/ly outputs.
import vga_pkg::*;

module vga_timing_gen #(
  parameter int   CLK_DIV   = 4,
  parameter int   H_VISIBLE = VGA_H_VISIBLE,
  parameter int   H_FP      = VGA_H_FP,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BP      = VGA_H_BP,
  parameter int   V_VISIBLE = VGA_V_VISIBLE,
  parameter int   V_FP      = VGA_V_FP,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BP      = VGA_V_BP,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       blanking,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
`ifdef VGA_CELL_COORD_EN
  ,
  output logic [3:0] cell,
  output logic [9:0] lx,
  output logic [9:0] ly
`endif
);

  localparam logic [9:0] X_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       tick;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       hs_on;
  logic       vs_on;

  clk_en_div #(.DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign pix_en = tick;

  always_comb begin
    y_nxt = y;
    if (x == X_LAST) begin
      x_nxt = 10'd0;
      if (y == Y_LAST) begin
        y_nxt = 10'd0;
      end else begin
        y_nxt = y + 10'd1;
      end
    end else begin
      x_nxt = x + 10'd1;
    end
  end

  assign hs_on = (x_nxt >= HS_START) && (x_nxt < HS_END);
  assign vs_on = (y_nxt >= VS_START) && (y_nxt < VS_END);

  // Decode is done on the next coordinates so every output shares the x/y register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= 10'd0;
      y           <= 10'd0;
      blanking    <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else if (tick) begin
      x           <= x_nxt;
      y           <= y_nxt;
      blanking    <= (x_nxt >= X_VIS) || (y_nxt >= Y_VIS);
      hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
      frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
    end else begin
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_CELL_COORD_EN
  localparam logic [9:0] BX0       = 10'(BOARD_X0);
  localparam logic [9:0] CELL_LAST = 10'(CELL_SZ - 1);

  logic [1:0] col;
  logic [1:0] row;
  logic [1:0] col_nxt;
  logic [1:0] row_nxt;
  logic [9:0] lx_cnt;
  logic [9:0] ly_cnt;
  logic [9:0] lx_nxt;
  logic [9:0] ly_nxt;
  logic       line_wrap;
  logic       on_board;

  assign line_wrap = (x == X_LAST);

  // Column/lx follow x one step at a time; cell edges are detected by lx reaching CELL_SZ-1.
  always_comb begin
    col_nxt = col;
    lx_nxt  = lx_cnt;
    if (x_nxt == BX0) begin
      col_nxt = 2'd0;
      lx_nxt  = 10'd0;
    end else if (col == IDX_NONE || x_nxt == 10'd0) begin
      col_nxt = IDX_NONE;
      lx_nxt  = 10'd0;
    end else if (lx_cnt == CELL_LAST) begin
      col_nxt = (col == 2'd2) ? IDX_NONE : col + 2'd1;
      lx_nxt  = 10'd0;
    end else begin
      lx_nxt  = lx_cnt + 10'd1;
    end
  end

  always_comb begin
    row_nxt = row;
    ly_nxt  = ly_cnt;
    if (!line_wrap) begin
      row_nxt = row;
    end else if (y_nxt == 10'd0) begin
      row_nxt = 2'd0;
      ly_nxt  = 10'd0;
    end else if (row == IDX_NONE) begin
      ly_nxt  = 10'd0;
    end else if (ly_cnt == CELL_LAST) begin
      row_nxt = (row == 2'd2) ? IDX_NONE : row + 2'd1;
      ly_nxt  = 10'd0;
    end else begin
      ly_nxt  = ly_cnt + 10'd1;
    end
  end

  assign on_board = (col_nxt != IDX_NONE) && (row_nxt != IDX_NONE);

  // Row tracking starts on-board because the raster resets to y = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= IDX_NONE;
      row    <= 2'd0;
      lx_cnt <= 10'd0;
      ly_cnt <= 10'd0;
      cell   <= CELL_NONE;
      lx     <= 10'd0;
      ly     <= 10'd0;
    end else if (tick) begin
      col    <= col_nxt;
      row    <= row_nxt;
      lx_cnt <= lx_nxt;
      ly_cnt <= ly_nxt;
      cell   <= on_board ? cell_index(row_nxt, col_nxt) : CELL_NONE;
      lx     <= on_board ? lx_nxt : 10'd0;
      ly     <= on_board ? ly_nxt : 10'd0;
    end else begin
      cell   <= cell;
    end
  end
`endif

endmodule
